// File: rtl/alu_bist_ctrl.sv
// Built-in self-test sequencer for the integer ALU: walks every opcode with two
// fixed operand vectors, folds each result into a MISR and checks it against a golden value.
module alu_bist_ctrl #(
    parameter int          WIDTH   = 32,
    parameter int          NUM_OPS = 12,
    parameter int          SETTLE  = 1,
    parameter logic [31:0] POLY    = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] alu_extra,
    output logic [3:0]       opcode,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             carryin,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0]       LAST_OP   = 4'(NUM_OPS - 1);
    localparam logic [3:0]       SETTLE_M1 = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [WIDTH-1:0] POLY_W    = WIDTH'(POLY);

    // Galois-style MISR step: shift left, fold the polynomial in when the MSB falls out.
    function automatic logic [WIDTH-1:0] misr_shift(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY_W : '0);
    endfunction

    function automatic logic [WIDTH-1:0] vec_a(input logic v);
        return v ? {WIDTH/4{4'b0110}} : {WIDTH/4{4'b1010}};
    endfunction

    function automatic logic [WIDTH-1:0] vec_b(input logic v);
        return v ? {WIDTH/4{4'b0110}} : {WIDTH/4{4'b0101}};
    endfunction

    logic [2:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [WIDTH-1:0] sig_next;

    assign sig_next = misr_shift(sig_q) ^ alu_out ^ alu_extra;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        sig_d   = sig_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    op_d    = 4'd0;
                    vec_d   = 1'b0;
                    a_d     = vec_a(1'b0);
                    b_d     = vec_b(1'b0);
                    cin_d   = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    sig_d   = '1;
                end
            end
            S_APPLY: begin
                if (SETTLE > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = SETTLE_M1;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                sig_d = sig_next;
                if (!vec_q) begin
                    state_d = S_APPLY;
                    vec_d   = 1'b1;
                    a_d     = vec_a(1'b1);
                    b_d     = vec_b(1'b1);
                    cin_d   = 1'b1;
                end else if (op_q != LAST_OP) begin
                    state_d = S_APPLY;
                    op_d    = op_q + 4'd1;
                    vec_d   = 1'b0;
                    a_d     = vec_a(1'b0);
                    b_d     = vec_b(1'b0);
                    cin_d   = 1'b0;
                end else begin
                    // Last vector: operands stay as they are so the ALU keeps its final inputs.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (sig_next == golden);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            vec_q   <= 1'b0;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            sig_q   <= sig_d;
        end
    end

    assign opcode    = op_q;
    assign a         = a_q;
    assign b         = b_q;
    assign carryin   = cin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: stub ALU (out=a^b, extra=opcode), independent MISR model,
// default instance plus a SETTLE=0 / NUM_OPS=4 instance.
module tb_alu_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic [31:0] golden, golden2;

    logic [3:0]  opcode, opcode2;
    logic [31:0] a, b, a2, b2;
    logic        carryin, carryin2;
    logic        busy, busy2, done, done2, pass, pass2;
    logic [31:0] signature, signature2;
    logic [31:0] alu_out, alu_extra, alu_out2, alu_extra2;

    assign alu_out    = a ^ b;
    assign alu_extra  = {28'b0, opcode};
    assign alu_out2   = a2 ^ b2;
    assign alu_extra2 = {28'b0, opcode2};

    always #5 clk = ~clk;

    alu_bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .golden(golden),
        .alu_out(alu_out), .alu_extra(alu_extra),
        .opcode(opcode), .a(a), .b(b), .carryin(carryin),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    alu_bist_ctrl #(.WIDTH(32), .NUM_OPS(4), .SETTLE(0), .POLY(32'h04C11DB7)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .golden(golden2),
        .alu_out(alu_out2), .alu_extra(alu_extra2),
        .opcode(opcode2), .a(a2), .b(b2), .carryin(carryin2),
        .busy(busy2), .done(done2), .pass(pass2), .signature(signature2)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        busy;
        logic        done;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
    } row_t;

    vec_t exp_q[$];
    row_t tbl[5];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mshift(input logic [31:0] s);
        logic [31:0] r;
        r = s << 1;
        if (s[31]) r = r ^ 32'h04C11DB7;
        return r;
    endfunction

    function automatic logic [31:0] pat_a(input int v);
        return (v == 0) ? 32'hAAAAAAAA : 32'h66666666;
    endfunction

    function automatic logic [31:0] pat_b(input int v);
        return (v == 0) ? 32'h55555555 : 32'h66666666;
    endfunction

    function automatic logic [31:0] model_sig(input int nops);
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        for (int op = 0; op < nops; op++)
            for (int v = 0; v < 2; v++)
                s = mshift(s) ^ (pat_a(v) ^ pat_b(v)) ^ 32'(op);
        return s;
    endfunction

    task automatic push_vectors(input int nops);
        vec_t e;
        for (int op = 0; op < nops; op++)
            for (int v = 0; v < 2; v++) begin
                e.op  = 4'(op);
                e.a   = pat_a(v);
                e.b   = pat_b(v);
                e.cin = (v == 1);
                exp_q.push_back(e);
            end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_opcode"}, 32'(opcode), 32'd0);
        chk({tag, "_a"}, a, 32'd0);
        chk({tag, "_b"}, b, 32'd0);
        chk({tag, "_cin"}, 32'(carryin), 32'd0);
        chk({tag, "_sig"}, signature, 32'd0);
    endtask

    // Full default run: vectors checked from the scoreboard queue, landmark cycles from the table.
    task automatic run_default(input bit good, input bit pulse);
        logic [31:0] m;
        int          dn;
        vec_t        e;
        m      = model_sig(12);
        golden = good ? m : (m ^ 32'd1);
        exp_q.delete();
        push_vectors(12);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dn = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (c <= 72 && (c - 1) % 3 == 0) begin
                if (exp_q.size() == 0) begin
                    chk("vec_queue_underflow", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("vec_opcode", 32'(opcode), 32'(e.op));
                    chk("vec_a", a, e.a);
                    chk("vec_b", b, e.b);
                    chk("vec_cin", 32'(carryin), 32'(e.cin));
                    chk("vec_busy", 32'(busy), 32'd1);
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (tbl[i].cyc == c) begin
                    chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
                    chk("tbl_done", 32'(done), 32'(tbl[i].done));
                    chk("tbl_opcode", 32'(opcode), 32'(tbl[i].op));
                    chk("tbl_a", a, tbl[i].a);
                    chk("tbl_b", b, tbl[i].b);
                    chk("tbl_cin", 32'(carryin), 32'(tbl[i].cin));
                end
            end
            if (pulse && (c == 10 || c == 73)) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        chk("done_pulses", 32'(dn), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);
        chk("pass", 32'(pass), 32'(good));
        chk("signature", signature, m);
    endtask

    initial begin
        tbl[0] = '{1,  1'b1, 1'b0, 4'd0,  32'hAAAAAAAA, 32'h55555555, 1'b0};
        tbl[1] = '{4,  1'b1, 1'b0, 4'd0,  32'h66666666, 32'h66666666, 1'b1};
        tbl[2] = '{7,  1'b1, 1'b0, 4'd1,  32'hAAAAAAAA, 32'h55555555, 1'b0};
        tbl[3] = '{73, 1'b0, 1'b1, 4'd11, 32'h66666666, 32'h66666666, 1'b1};
        tbl[4] = '{74, 1'b0, 1'b0, 4'd11, 32'h66666666, 32'h66666666, 1'b1};

        rst_n = 1'b1; start = 1'b0; start2 = 1'b0;
        golden = 32'd0; golden2 = 32'd0;

        // Reset asserted between clock edges must clear outputs immediately.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_opcode", 32'(opcode), 32'd0);

        run_default(1'b1, 1'b0);
        run_default(1'b0, 1'b0);
        run_default(1'b1, 1'b1);

        // Abort mid-run: no done pulse, everything back to reset values.
        golden = model_sig(12);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        begin
            int dn;
            dn = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (done) dn++;
            end
            rst_n = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (done || busy) dn++;
            end
            chk("abort_no_done", 32'(dn), 32'd0);
        end
        run_default(1'b1, 0);

        // Short configuration: 2 cycles per vector, four opcodes.
        begin
            int          dn, dcyc;
            logic [3:0]  maxop;
            golden2 = model_sig(4);
            dn = 0; dcyc = -1; maxop = 4'd0;
            @(negedge clk) start2 = 1'b1;
            @(posedge clk);
            #1 start2 = 1'b0;
            for (int c = 1; c <= 25; c++) begin
                @(negedge clk);
                if (opcode2 > maxop) maxop = opcode2;
                if (done2) begin
                    dn++;
                    dcyc = c;
                end
                if (c == 3) begin
                    chk("s0_vec1_a", a2, 32'h66666666);
                    chk("s0_vec1_cin", 32'(carryin2), 32'd1);
                end
                if (c == 5) chk("s0_op1", 32'(opcode2), 32'd1);
            end
            chk("s0_done_cycle", 32'(dcyc), 32'd17);
            chk("s0_done_pulses", 32'(dn), 32'd1);
            chk("s0_max_opcode", 32'(maxop), 32'd3);
            chk("s0_signature", signature2, model_sig(4));
            chk("s0_pass", 32'(pass2), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
